// File: rtl/dense_requant_writeback_pkg.sv
// Shared types and constants for the dense-layer requantize/writeback stage
// and the reusable requant pipeline.
package dense_requant_writeback_pkg;

    localparam int MAX_OUT = 64;
    localparam int ADDR_W  = 8;
    localparam int ACC_W   = 32;
    localparam int IDX_W   = 6;

    localparam logic signed [7:0] INT8_MIN = 8'sh80;
    localparam logic signed [7:0] INT8_MAX = 8'sh7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic signed [31:0] mult;
        logic [4:0]         shift;
        logic signed [7:0]  zp;
        logic               relu_en;
    } requant_cfg_t;

endpackage

// File: rtl/dense_requant_writeback_requant_unit.sv
// Two-stage requantizer: Q31 multiply, then round/shift, zero point,
// int8 saturation and optional quantized ReLU. A tag rides along with each element.
module requant_unit
    import dense_requant_writeback_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid_i,
    input  logic signed [ACC_W-1:0] in_acc_i,
    input  logic [TAG_W-1:0]        in_tag_i,
    input  logic signed [31:0]      mult_i,
    input  logic [4:0]              shift_i,
    input  logic signed [7:0]       zp_i,
    input  logic                    relu_en_i,
    output logic                    mid_valid_o,
    output logic                    out_valid_o,
    output logic signed [7:0]       out_data_o,
    output logic [TAG_W-1:0]        out_tag_o
);

    logic signed [63:0] acc_ext, mult_ext, prod_q;
    logic               mid_valid_q, out_valid_q;
    logic [TAG_W-1:0]   mid_tag_q, out_tag_q;
    logic signed [7:0]  out_data_q, res_d;

    logic [5:0]         s;
    logic signed [63:0] rnd, sum, r, zp_ext, v;

    assign acc_ext  = {{(64-ACC_W){in_acc_i[ACC_W-1]}}, in_acc_i};
    assign mult_ext = {{32{mult_i[31]}}, mult_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            mid_valid_q <= 1'b0;
            mid_tag_q   <= '0;
            prod_q      <= '0;
        end else begin
            mid_valid_q <= in_valid_i;
            mid_tag_q   <= in_tag_i;
            prod_q      <= acc_ext * mult_ext;
        end
    end

    // |acc * mult| <= 2^62, so adding the half-LSB never overflows 64 bits.
    always_comb begin
        s      = 6'd31 + {1'b0, shift_i};
        rnd    = 64'sd1 <<< (s - 6'd1);
        sum    = prod_q + rnd;
        r      = sum >>> s;
        zp_ext = {{56{zp_i[7]}}, zp_i};
        v      = r + zp_ext;
        if (v > 64'sd127) begin
            res_d = INT8_MAX;
        end else if (v < -64'sd128) begin
            res_d = INT8_MIN;
        end else begin
            res_d = v[7:0];
        end
        if (relu_en_i && (res_d < zp_i)) begin
            res_d = zp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= mid_valid_q;
            out_tag_q   <= mid_tag_q;
            out_data_q  <= res_d;
        end
    end

    assign mid_valid_o = mid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_tag_o   = out_tag_q;

endmodule

// File: rtl/dense_requant_writeback.sv
// Dense-layer writeback: walks the accumulator vector through the requant
// pipeline, writes int8 results to tensor RAM and tracks the argmax.
module dense_requant_writeback
    import dense_requant_writeback_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic [MAX_OUT*ACC_W-1:0]   acc_vector_i,
    input  logic [6:0]                 output_size_i,
    input  logic [31:0]                quant_mult_i,
    input  logic [4:0]                 quant_shift_i,
    input  logic [7:0]                 out_zero_point_i,
    input  logic                       relu_en_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    output logic                       tensor_ram_we_o,
    output logic [ADDR_W-1:0]          tensor_ram_waddr_o,
    output logic [7:0]                 tensor_ram_din_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [IDX_W-1:0]           argmax_idx_o,
    output logic [7:0]                 argmax_val_o
);

    state_t                  state_q, state_d;
    requant_cfg_t            cfg_q;
    logic [6:0]              size_q, size_clamped;
    logic [ADDR_W-1:0]       base_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] s1_acc_q;
    logic [IDX_W-1:0]        s1_idx_q;
    logic                    done_q;
    logic [IDX_W-1:0]        argmax_idx_q;
    logic signed [7:0]       argmax_val_q;
    logic                    argmax_first_q;

    logic                    start_ok, issue, last_issue;
    logic                    rq_mid_valid, rq_valid;
    logic signed [7:0]       rq_data;
    logic [IDX_W-1:0]        rq_idx;
    logic [ACC_W-1:0]        acc_arr [MAX_OUT];

    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_unpack
        assign acc_arr[gi] = acc_vector_i[gi*ACC_W +: ACC_W];
    end

    assign size_clamped = (output_size_i > 7'd64) ? 7'd64 : output_size_i;
    assign start_ok     = start_i && (state_q == ST_IDLE);
    assign issue        = (state_q == ST_RUN);
    assign last_issue   = issue && ({1'b0, idx_q} == size_q - 7'd1);

    // An empty pass falls through DRAIN (trivially empty) so done still lands two cycles after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = (size_clamped != 7'd0) ? ST_RUN : ST_DRAIN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q && !rq_mid_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            size_q     <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_acc_q   <= '0;
            s1_idx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_q == ST_DONE);
            s1_valid_q <= issue;
            if (start_ok) begin
                cfg_q.mult    <= quant_mult_i;
                cfg_q.shift   <= quant_shift_i;
                cfg_q.zp      <= out_zero_point_i;
                cfg_q.relu_en <= relu_en_i;
                size_q        <= size_clamped;
                base_q        <= base_addr_i;
                idx_q         <= '0;
            end else if (issue) begin
                idx_q <= idx_q + 1'b1;
            end
            if (issue) begin
                s1_acc_q <= acc_arr[idx_q];
                s1_idx_q <= idx_q;
            end
        end
    end

    requant_unit #(.TAG_W(IDX_W)) u_requant (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (s1_valid_q),
        .in_acc_i    (s1_acc_q),
        .in_tag_i    (s1_idx_q),
        .mult_i      (cfg_q.mult),
        .shift_i     (cfg_q.shift),
        .zp_i        (cfg_q.zp),
        .relu_en_i   (cfg_q.relu_en),
        .mid_valid_o (rq_mid_valid),
        .out_valid_o (rq_valid),
        .out_data_o  (rq_data),
        .out_tag_o   (rq_idx)
    );

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            argmax_idx_q   <= '0;
            argmax_val_q   <= '0;
            argmax_first_q <= 1'b0;
        end else if (start_ok) begin
            argmax_idx_q   <= '0;
            argmax_val_q   <= '0;
            argmax_first_q <= 1'b1;
        end else if (rq_valid) begin
            argmax_first_q <= 1'b0;
            if (argmax_first_q || (rq_data > argmax_val_q)) begin
                argmax_idx_q <= rq_idx;
                argmax_val_q <= rq_data;
            end
        end
    end

    assign tensor_ram_we_o    = rq_valid;
    assign tensor_ram_waddr_o = base_q + {{(ADDR_W-IDX_W){1'b0}}, rq_idx};
    assign tensor_ram_din_o   = rq_data;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = done_q;
    assign argmax_idx_o       = argmax_idx_q;
    assign argmax_val_o       = argmax_val_q;

endmodule

// File: tb/tb_dense_requant_writeback.sv
// Randomized and directed bench for dense_requant_writeback against a
// plain-arithmetic model of the requantization, write schedule and argmax.
module tb_dense_requant_writeback;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2047:0] acc_vec;
    logic [6:0]   output_size;
    logic [31:0]  quant_mult;
    logic [4:0]   quant_shift;
    logic [7:0]   zero_point;
    logic         relu_en;
    logic [7:0]   base_addr;
    logic         we;
    logic [7:0]   waddr;
    logic [7:0]   din;
    logic         busy;
    logic         done;
    logic [5:0]   amax_idx;
    logic [7:0]   amax_val;

    always #5 clk = ~clk;

    dense_requant_writeback dut (
        .clk                (clk),
        .reset              (reset),
        .start_i            (start),
        .acc_vector_i       (acc_vec),
        .output_size_i      (output_size),
        .quant_mult_i       (quant_mult),
        .quant_shift_i      (quant_shift),
        .out_zero_point_i   (zero_point),
        .relu_en_i          (relu_en),
        .base_addr_i        (base_addr),
        .tensor_ram_we_o    (we),
        .tensor_ram_waddr_o (waddr),
        .tensor_ram_din_o   (din),
        .busy_o             (busy),
        .done_o             (done),
        .argmax_idx_o       (amax_idx),
        .argmax_val_o       (amax_val)
    );

    int checks = 0;
    int failures = 0;

    longint cyc = 0;
    longint c0 = 0;
    bit     mon_en = 1'b0;
    int     exp_n = 0;
    int     done_j = 0;
    int     exp_addr [64];
    int     exp_val [64];
    int     exp_amax_idx = 0;
    int     exp_amax_val = 0;
    int     cap [64];
    int     capa [64];
    logic signed [31:0] acc_m [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Requantize one accumulator straight from the arithmetic definition.
    function automatic int model_val(input logic signed [31:0] acc, input logic signed [31:0] mult,
                                     input int sh, input int zp, input bit relu);
        longint p, r, v;
        int s;
        p = longint'(acc) * longint'(mult);
        s = 31 + sh;
        r = (p + (longint'(1) << (s - 1))) >>> s;
        v = r + zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        if (relu && v < zp) v = zp;
        return int'(v);
    endfunction

    // Compare process: j counts cycles since the edge that accepted start.
    always @(negedge clk) begin
        longint j;
        bit ew;
        if (mon_en) begin
            j  = cyc - c0;
            ew = (j >= 3) && (j < 3 + exp_n);
            check("we", longint'(we), longint'(ew));
            if (ew) begin
                check("waddr", longint'(waddr), exp_addr[int'(j - 3)]);
                check("din", longint'($signed(din)), exp_val[int'(j - 3)]);
                cap[int'(j - 3)]  = int'($signed(din));
                capa[int'(j - 3)] = int'(waddr);
            end
            check("done", longint'(done), longint'(j == done_j));
            check("busy", longint'(busy), longint'((j >= 0) && (j < done_j)));
            if (j == done_j) begin
                check("argmax_idx", longint'(amax_idx), exp_amax_idx);
                check("argmax_val", longint'($signed(amax_val)), exp_amax_val);
            end
        end
    end

    task automatic run_pass(input int size_raw, input logic [31:0] mult, input int sh, input int zp,
                            input bit relu, input int base, input bit repulse);
        int n;
        @(posedge clk); #2;
        n = (size_raw > 64) ? 64 : size_raw;
        for (int i = 0; i < 64; i++) begin
            acc_vec[i*32 +: 32] = acc_m[i];
            cap[i]  = -999;
            capa[i] = -999;
        end
        for (int i = 0; i < n; i++) begin
            exp_val[i]  = model_val(acc_m[i], mult, sh, zp, relu);
            exp_addr[i] = (base + i) % 256;
        end
        exp_amax_idx = 0;
        exp_amax_val = (n > 0) ? exp_val[0] : 0;
        for (int i = 1; i < n; i++) begin
            if (exp_val[i] > exp_amax_val) begin
                exp_amax_idx = i;
                exp_amax_val = exp_val[i];
            end
        end
        exp_n       = n;
        done_j      = (n == 0) ? 2 : n + 4;
        output_size = size_raw[6:0];
        quant_mult  = mult;
        quant_shift = sh[4:0];
        zero_point  = zp[7:0];
        relu_en     = relu;
        base_addr   = base[7:0];
        start       = 1'b1;
        c0          = cyc + 1;
        mon_en      = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        if (repulse && n > 0) begin
            @(posedge clk); #2;
            start       = 1'b1;
            quant_mult  = $urandom;
            quant_shift = 5'($urandom);
            zero_point  = 8'($urandom);
            relu_en     = ~relu;
            base_addr   = 8'($urandom);
            output_size = 7'($urandom_range(1, 64));
            @(posedge clk); #2;
            start = 1'b0;
            while (cyc - c0 < done_j - 1) begin
                @(posedge clk); #2;
            end
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        while (cyc - c0 < done_j + 2) begin
            @(posedge clk); #2;
        end
        $display("pass size=%0d n=%0d mult=%08h shift=%0d zp=%0d relu=%0d base=%02h argmax=%0d/%0d",
                 size_raw, n, mult, sh, zp, relu, base, exp_amax_idx, exp_amax_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; acc_vec = '0; output_size = '0; quant_mult = '0;
        quant_shift = '0; zero_point = '0; relu_en = 1'b0; base_addr = '0;
        for (int i = 0; i < 64; i++) acc_m[i] = '0;
        repeat (4) @(posedge clk);
        #2;
        check("rst_we", longint'(we), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_amax_idx", longint'(amax_idx), 0);
        check("rst_amax_val", longint'(amax_val), 0);
        check("rst_din", longint'(din), 0);
        reset = 1'b0;

        // Basic pass
        acc_m[0] = 100; acc_m[1] = 101; acc_m[2] = -101; acc_m[3] = 0;
        check("pin_model_100", model_val(32'sd100, 32'h40000000, 0, 0, 0), 50);
        check("pin_model_m101", model_val(-32'sd101, 32'h40000000, 0, 0, 0), -50);
        run_pass(4, 32'h40000000, 0, 0, 0, 'h10, 0);
        check("basic_w0", cap[0], 50);
        check("basic_w1", cap[1], 51);
        check("basic_w2", cap[2], -50);
        check("basic_w3", cap[3], 0);
        check("basic_addr3", capa[3], 'h13);
        check("basic_amax_idx", longint'(amax_idx), 1);
        check("basic_amax_val", longint'($signed(amax_val)), 51);

        // Saturation
        acc_m[0] = 1000; acc_m[1] = -1000;
        run_pass(2, 32'h7FFFFFFF, 0, 0, 0, 0, 0);
        check("sat_hi", cap[0], 127);
        check("sat_lo", cap[1], -128);

        // ReLU and zero point
        acc_m[0] = -20;
        run_pass(1, 32'h40000000, 0, 5, 1, 'h20, 0);
        check("relu_on", cap[0], 5);
        run_pass(1, 32'h40000000, 0, 5, 0, 'h20, 0);
        check("relu_off", cap[0], -5);

        // Shift and address wrap
        acc_m[0] = 320; acc_m[1] = 320;
        run_pass(2, 32'h40000000, 4, 0, 0, 'hFF, 0);
        check("shift_val", cap[0], 10);
        check("wrap_addr0", capa[0], 'hFF);
        check("wrap_addr1", capa[1], 'h00);

        // Control edge cases
        run_pass(0, 32'h40000000, 0, 0, 0, 'h40, 0);
        for (int i = 0; i < 64; i++) acc_m[i] = $signed(32'($urandom_range(0, 4000))) - 2000;
        run_pass(6, 32'h40000000, 1, -3, 0, 'h30, 1);
        acc_m[0] = 7; acc_m[1] = 7;
        run_pass(2, 32'h7FFFFFFF, 0, 0, 0, 0, 0);
        check("tie_amax_idx", longint'(amax_idx), 0);
        check("tie_amax_val", longint'($signed(amax_val)), 7);
        for (int i = 0; i < 64; i++) acc_m[i] = $signed(32'($urandom_range(0, 4000))) - 2000;
        run_pass(100, 32'h20000000, 2, 0, 0, 'hC0, 0);

        // Randomized passes
        for (int t = 0; t < 20; t++) begin
            logic [31:0] m;
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) acc_m[i] = $signed($urandom);
                else acc_m[i] = $signed(32'($urandom_range(0, 20000))) - 10000;
            end
            m = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(32'h08000000, 32'h7FFFFFFF));
            run_pass($urandom_range(0, 70), m, $urandom_range(0, 31) % (($urandom_range(0, 1) == 1) ? 32 : 4),
                     int'($urandom_range(0, 255)) - 128, bit'($urandom_range(0, 1)),
                     $urandom_range(0, 255), bit'($urandom_range(0, 1)));
        end

        // Reset mid-pass
        @(posedge clk); #2;
        mon_en = 1'b0;
        for (int i = 0; i < 64; i++) acc_m[i] = 32'sd500 + 32'(i);
        for (int i = 0; i < 64; i++) acc_vec[i*32 +: 32] = acc_m[i];
        output_size = 7'd10; quant_mult = 32'h40000000; quant_shift = 5'd0;
        zero_point = 8'd0; relu_en = 1'b0; base_addr = 8'h00;
        start = 1'b1;
        c0 = cyc + 1;
        @(posedge clk); #2;
        start = 1'b0;
        while (cyc - c0 < 4) begin
            @(posedge clk); #2;
        end
        check("mid_second_write", longint'(we), 1);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            check("rstmid_we", longint'(we), 0);
            check("rstmid_busy", longint'(busy), 0);
            check("rstmid_done", longint'(done), 0);
            check("rstmid_amax", longint'({amax_idx, amax_val}), 0);
        end
        $display("reset mid-pass issued after second write");
        reset = 1'b0;
        run_pass(10, 32'h40000000, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dense_requant_writeback.md
Name: dense_requant_writeback

Overview:
Downstream stage of the dense layer compute block. Once the dense block signals completion, this block takes its 64 x 32-bit pre-activation accumulator vector. For each valid neuron it applies fixed-point requantization, adds the output zero point, saturates to int8 and optionally applies ReLU. Results are written sequentially into tensor RAM for the next layer. It also tracks the argmax of the written values for final-layer classification.

Parameters:
MAX_OUT, 64, maximum neuron count (acc_vector depth)
ADDR_W, 8, tensor RAM address width
ACC_W, 32, accumulator width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a pass; ignored unless IDLE
acc_vector  input  ACC_W x MAX_OUT  pre-activation accumulators; must be held stable while busy
output_size  input  7  neuron count, 0..64; sampled at start
quant_mult  input  32  signed Q31 multiplier; sampled at start
quant_shift  input  5  extra right shift, 0..31; sampled at start
out_zero_point  input  8  signed output zero point; sampled at start
relu_en  input  1  enables quantized ReLU; sampled at start
base_addr  input  ADDR_W  first tensor RAM write address; sampled at start
tensor_ram_we  output  1  write strobe
tensor_ram_waddr  output  ADDR_W  write address
tensor_ram_din  output  8  int8 result
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last write
argmax_idx  output  6  index of the largest written value
argmax_val  output  8  that value, signed

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all indices cleared. A reset asserted mid-pass aborts the pass immediately, produces no further writes, and holds argmax at 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start latches the config, clears idx and argmax, then goes to RUN. If output_size == 0, go directly to DONE with no writes.
  - RUN: issue idx into the pipeline each cycle. After idx == output_size-1 is issued, go to DRAIN.
  - DRAIN: wait until the pipeline is empty (last write emitted), then go to DONE.
  - DONE: assert done for exactly one cycle, then return to IDLE.
- Pipeline, 3 stages, one element per cycle with no bubbles:
  - S1: register acc_vector[idx] and idx.
  - S2: signed 64-bit product p = acc * quant_mult.
  - S3: compute the result and write.
- S3 arithmetic:
  - s = 31 + quant_shift.
  - r = (p + (1 << (s-1))) >>> s. This is arithmetic shift with round-half-toward-+inf. The 64-bit signed sum cannot overflow.
  - v = r + out_zero_point, computed at 34 bits or wider.
  - Saturate v to [-128, 127].
  - If relu_en, v = max(v, out_zero_point).
- Write: tensor_ram_we = 1, waddr = base_addr + idx (mod 2^ADDR_W), din = v.
- Latency: the first write occurs 3 cycles after entering RUN. A full pass takes output_size + 4 cycles from start to done.
- Argmax:
  - Updated on each write when v > argmax_val (signed), or on the first element.
  - Ties keep the lower index.
  - Value is valid from done onward and held until the next accepted start.
- start during busy or DONE: ignored, with no effect on config.
- output_size > 64: treated as 64.

Decomposition:
- Shared package:
  - requant config struct (mult, shift, zp, relu_en).
  - state enum.
  - constants INT8_MIN/INT8_MAX and MAX_OUT.
- One natural sub-module: requant_unit. It is a 2-stage pipeline (multiply, then round/shift/zp/saturate/ReLU) and is reusable by the conv path.
- The top level keeps the FSM, the index counter, the write port and argmax.

Test Plan:
- Basic pass:
  - Stimulus: mult 0x40000000, shift 0, zp 0, relu 0, output_size 4, acc = {100, 101, -101, 0}, base 0x10.
  - Required response: writes 50, 51, -50, 0 to addresses 0x10..0x13 on consecutive cycles; done at start+8 cycles; argmax_idx 1, argmax_val 51.
- Saturation:
  - Stimulus: mult 0x7FFFFFFF, shift 0, acc = {1000, -1000}.
  - Required response: writes 127, -128.
- ReLU and zero point:
  - Stimulus: mult 0x40000000, zp 5, acc = -20.
  - Required response: with relu_en = 1, write 5; with relu_en = 0, write -5.
- Shift and address wrap:
  - Stimulus: quant_shift 4, mult 0x40000000, acc 320, base 0xFF, output_size 2.
  - Required response: first result 10 written at 0xFF, second written at 0x00.
- Control edge cases:
  - Stimulus: output_size 0.
  - Required response: done 2 cycles after start, no writes.
  - Stimulus: start re-pulsed during RUN.
  - Required response: ignored.
  - Stimulus: argmax tie, acc = {7, 7} with a unity-like multiplier.
  - Required response: argmax_idx 0.
- Reset mid-pass:
  - Stimulus: assert reset after the 2nd write of a 10-element pass.
  - Required response: no further we; busy, done and argmax all 0; a subsequent start runs a clean full pass.
